modulo_counter: RTL and testbench

//  Parametrised up/down modulo counter with prescaler, parallel load, clear, wrap/saturate mode.

---
 rtl/counter_pkg.sv | 18 +
 rtl/modulo_counter_prescaler.sv | 33 +++
 rtl/modulo_counter.sv | 94 +++++++++
 tb/tb_modulo_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter.
// Mode encodings and prescaler width sizing.
package counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int clog2(input longint unsigned v);
    int r;
    r = 1;
    for (int i = 1; i < 63; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/modulo_counter_prescaler.sv
// Enabled-cycle divider for the modulo counter.
// tick marks the enabled cycle that completes a period.
module prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = clog2(longint'(PRESCALE));
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Count enabled cycles, restarting after each tick.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/modulo_counter.sv
// Up/down modulo counter with prescaler, load and clear.
// Wraps or saturates at range ends, flags end steps.
module modulo_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 5,
  parameter longint MODULUS  = 32,
  parameter int     PRESCALE = 1,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             overflow,
  output logic             load_error
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("modulo_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("modulo_counter: MODULUS out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_pre
    $error("modulo_counter: PRESCALE out of range");
  end

  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP = MAXV[WIDTH-1:0];
  localparam bit SAT = (SATURATE == MODE_SATURATE);

  logic             tick;
  logic [WIDTH:0]   ext;
  logic             at_top;
  logic             at_bot;
  logic             hit;
  logic             bad_load;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_cnt;

  prescaler #(
    .PRESCALE(PRESCALE)
  ) u_pre (
    .clock (clock),
    .reset (reset),
    .clear (clear | load),
    .enable(enable),
    .tick  (tick)
  );

  // Next step value and range-end detection, compared one bit wide
  // so MODULUS = 2**WIDTH cannot truncate.
  always_comb begin
    ext      = {1'b0, count};
    at_top   = (ext == MAXV);
    at_bot   = (ext == '0);
    hit      = up ? at_top : at_bot;
    nxt      = count;
    if (hit) begin
      if (!SAT) nxt = up ? '0 : TOP;
    end else begin
      nxt = up ? count + 1'b1 : count - 1'b1;
    end
    bad_load = ({1'b0, load_value} > MAXV);
    load_cnt = bad_load ? TOP : load_value;
  end

  // Priority: reset/clear, then load, then step, else hold.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count      <= '0;
      terminal   <= 1'b0;
      overflow   <= 1'b0;
      load_error <= 1'b0;
    end else if (load) begin
      count    <= load_cnt;
      terminal <= 1'b0;
      if (bad_load) load_error <= 1'b1;
    end else if (tick) begin
      count    <= nxt;
      terminal <= hit;
      if (hit) overflow <= 1'b1;
    end else begin
      terminal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modulo_counter.sv
// Bench for modulo_counter: five configurations share one
// stimulus stream and are checked against an integer model.
module tb_modulo_counter;

  localparam int N = 5;
  localparam int MODS [N] = '{32, 10, 10, 10, 16};
  localparam int PRES [N] = '{1, 3, 1, 4, 1};
  localparam int SATS [N] = '{0, 0, 1, 0, 0};

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_value = '0;

  logic [4:0] dcnt [N];
  logic [3:0] dcnt4;
  logic       dterm [N];
  logic       dovf [N];
  logic       dlerr [N];

  assign dcnt[4] = {1'b0, dcnt4};

  int  mcnt [N];
  int  mpre [N];
  bit  mterm [N];
  bit  movf [N];
  bit  mlerr [N];

  int  tests = 0;
  int  fails = 0;
  bit  checking = 1'b0;

  always #5 clock = ~clock;

  modulo_counter #(.WIDTH(5), .MODULUS(32), .PRESCALE(1), .SATURATE(0)) u0 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .count(dcnt[0]), .terminal(dterm[0]), .overflow(dovf[0]),
    .load_error(dlerr[0]));

  modulo_counter #(.WIDTH(5), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .count(dcnt[1]), .terminal(dterm[1]), .overflow(dovf[1]),
    .load_error(dlerr[1]));

  modulo_counter #(.WIDTH(5), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u2 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .count(dcnt[2]), .terminal(dterm[2]), .overflow(dovf[2]),
    .load_error(dlerr[2]));

  modulo_counter #(.WIDTH(5), .MODULUS(10), .PRESCALE(4), .SATURATE(0)) u3 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value),
    .count(dcnt[3]), .terminal(dterm[3]), .overflow(dovf[3]),
    .load_error(dlerr[3]));

  modulo_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) u4 (
    .clock(clock), .reset(reset), .enable(enable), .up(up),
    .clear(clear), .load(load), .load_value(load_value[3:0]),
    .count(dcnt4), .terminal(dterm[4]), .overflow(dovf[4]),
    .load_error(dlerr[4]));

  // Reference model: integer count with modulo arithmetic.
  always @(posedge clock) begin
    for (int k = 0; k < N; k++) begin
      int lv;
      bit hit;
      lv = (k == 4) ? int'(load_value[3:0]) : int'(load_value);
      if (reset || clear) begin
        mcnt[k] = 0; mpre[k] = 0; mterm[k] = 0;
        movf[k] = 0; mlerr[k] = 0;
      end else if (load) begin
        mpre[k] = 0;
        mterm[k] = 0;
        if (lv >= MODS[k]) begin
          mcnt[k] = MODS[k] - 1;
          mlerr[k] = 1;
        end else begin
          mcnt[k] = lv;
        end
      end else begin
        mterm[k] = 0;
        if (enable) begin
          mpre[k] = mpre[k] + 1;
          if (mpre[k] == PRES[k]) begin
            mpre[k] = 0;
            hit = up ? (mcnt[k] == MODS[k] - 1) : (mcnt[k] == 0);
            if (hit) begin
              mterm[k] = 1;
              movf[k] = 1;
            end
            if (!hit || SATS[k] == 0)
              mcnt[k] = up ? (mcnt[k] + 1) % MODS[k]
                           : (mcnt[k] + MODS[k] - 1) % MODS[k];
          end
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clock) begin
    if (checking) begin
      for (int k = 0; k < N; k++) begin
        tests++;
        if (int'(dcnt[k]) != mcnt[k] || dterm[k] !== mterm[k] ||
            dovf[k] !== movf[k] || dlerr[k] !== mlerr[k]) begin
          fails++;
          $display("FAIL cmp inst%0d t=%0t got cnt=%0d term=%b ovf=%b lerr=%b exp cnt=%0d term=%b ovf=%b lerr=%b",
                   k, $time, dcnt[k], dterm[k], dovf[k], dlerr[k],
                   mcnt[k], mterm[k], movf[k], mlerr[k]);
        end
      end
    end
  end

  // Hand-computed expectation, checked against DUT and model.
  task automatic lit(input string name, input int got,
                     input int mdl, input int exp);
    tests++;
    if (got != exp || mdl != exp) begin
      fails++;
      $display("FAIL %s got=%0d model=%0d exp=%0d", name, got, mdl, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic en, input logic u,
                     input logic cl, input logic ld,
                     input logic [4:0] lv);
    reset = r; enable = en; up = u; clear = cl;
    load = ld; load_value = lv;
    @(posedge clock);
    #2;
  endtask

  initial begin
    cyc(1, 0, 1, 0, 0, 0);
    checking = 1'b1;
    cyc(1, 0, 1, 0, 0, 0);
    lit("rst_cnt", int'(dcnt[0]), mcnt[0], 0);
    lit("rst_ovf", int'(dovf[0]), int'(movf[0]), 0);

    for (int i = 1; i <= 33; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      if (i == 30) begin
        lit("m10_wrap_cnt", int'(dcnt[1]), mcnt[1], 0);
        lit("m10_wrap_term", int'(dterm[1]), int'(mterm[1]), 1);
      end
      if (i == 31) begin
        lit("t1_cnt31", int'(dcnt[0]), mcnt[0], 31);
        lit("t1_term31", int'(dterm[0]), int'(mterm[0]), 0);
      end
      if (i == 32) begin
        lit("t1_wrap_cnt", int'(dcnt[0]), mcnt[0], 0);
        lit("t1_wrap_term", int'(dterm[0]), int'(mterm[0]), 1);
        lit("t1_ovf", int'(dovf[0]), int'(movf[0]), 1);
      end
    end
    lit("t1_after", int'(dcnt[0]), mcnt[0], 1);
    lit("t1_term_low", int'(dterm[0]), int'(mterm[0]), 0);
    lit("m10_cnt33", int'(dcnt[1]), mcnt[1], 1);
    lit("sat_top", int'(dcnt[2]), mcnt[2], 9);

    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0);
    lit("freeze_cnt", int'(dcnt[1]), mcnt[1], 1);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    lit("freeze_pre", int'(dcnt[1]), mcnt[1], 1);
    cyc(0, 1, 1, 0, 0, 0);
    lit("resume_step", int'(dcnt[1]), mcnt[1], 2);

    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    lit("sat_bot_cnt", int'(dcnt[2]), mcnt[2], 0);
    lit("sat_bot_term", int'(dterm[2]), int'(mterm[2]), 1);
    lit("sat_bot_ovf", int'(dovf[2]), int'(movf[2]), 1);
    lit("w4_down15", int'(dcnt[4]), mcnt[4], 15);
    cyc(0, 1, 0, 0, 0, 0);
    lit("w4_down14", int'(dcnt[4]), mcnt[4], 14);
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0);
    lit("sat_up_cnt", int'(dcnt[2]), mcnt[2], 9);

    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 5'd7);
    lit("load7_cnt", int'(dcnt[0]), mcnt[0], 7);
    lit("load7_term", int'(dterm[0]), int'(mterm[0]), 0);
    cyc(0, 1, 1, 0, 1, 5'd12);
    lit("load12_cnt", int'(dcnt[1]), mcnt[1], 9);
    lit("load12_err", int'(dlerr[1]), int'(mlerr[1]), 1);
    lit("load12_m32", int'(dcnt[0]), mcnt[0], 12);

    cyc(0, 1, 1, 1, 1, 5'd7);
    lit("clr_cnt", int'(dcnt[0]), mcnt[0], 0);
    lit("clr_lerr", int'(dlerr[1]), int'(mlerr[1]), 0);

    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0);
    lit("pre4_hold", int'(dcnt[3]), mcnt[3], 0);
    cyc(0, 1, 1, 0, 0, 0);
    lit("pre4_step", int'(dcnt[3]), mcnt[3], 1);

    for (int i = 0; i < 10000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      cyc(r < 5, $urandom_range(0, 3) != 0, 1'($urandom),
          r >= 5 && r < 15, $urandom_range(0, 99) < 3,
          5'($urandom));
    end

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
